// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
// One Booth digit is retired per clock; signed or unsigned mode is latched per operation.
module booth_mult_seq #(
   parameter int unsigned N = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             tc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   p
);

   localparam int unsigned K  = (N + 2) / 2;
   localparam int unsigned W  = N + 2;
   localparam int unsigned AW = 2 * W;
   localparam int unsigned CW = $clog2(K) + 1;

   if ((N % 2) != 0 || N < 4) begin : g_param_check
      $error("booth_mult_seq: N must be even and >= 4");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   mcand_q, mcand_d;
   logic [W:0]      mplier_q, mplier_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [2*N-1:0]  p_q, p_d;
   logic [AW-1:0]   pp;
   logic [AW-1:0]   acc_sum;

   // mplier_q carries an implicit zero below bit 0, so its low three bits form the current digit.
   always_comb begin
      pp = '0;
      case (mplier_q[2:0])
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = mcand_q << 1;
         3'b100:         pp = -(mcand_q << 1);
         3'b101, 3'b110: pp = -mcand_q;
         default:        pp = '0;
      endcase
   end

   assign acc_sum = acc_q + pp;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      p_d      = p_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = {{(AW - N){tc & a[N-1]}}, a};
               mplier_d = {{2{tc & b[N-1]}}, b, 1'b0};
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = StBusy;
            end
         end
         StBusy: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 2;
            mplier_d = mplier_q >> 2;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(K - 1)) begin
               p_d     = acc_sum[2*N-1:0];
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         p_q      <= p_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign p         = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq (N=10): directed vector table, handshake corner sequences,
// and random operations checked against a plain-arithmetic product model.
module tb_booth_mult_seq;

   localparam int N = 10;
   localparam int K = (N + 2) / 2;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             tc;
   logic             out_valid;
   logic             out_ready;
   logic [2*N-1:0]   p;

   int n_tests;
   int n_fail;

   booth_mult_seq #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .tc        (tc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   va;
      logic [N-1:0]   vb;
      logic           vtc;
      logic [2*N-1:0] vexp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic s);
      longint xi;
      longint yi;
      longint prod;
      logic [63:0] r;
      xi = longint'(x);
      yi = longint'(y);
      if (s && x[N-1]) xi = xi - (64'sd1 <<< N);
      if (s && y[N-1]) yi = yi - (64'sd1 <<< N);
      prod = xi * yi;
      r = 64'(prod);
      return r[2*N-1:0];
   endfunction

   // Offer a pair and step through the accepting edge.
   task automatic start(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic ttc);
      int guard;
      guard = 0;
      a = ta;
      b = tb_;
      tc = ttc;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("accept_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // lat counts edges from the accepting edge (inclusive) to the edge raising out_valid.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                         input logic ttc, input logic [2*N-1:0] exp, input int stall,
                         input bit noise);
      int lat;
      start(ta, tb_, ttc);
      if (noise) begin
         // Operand and mode changes after capture must not disturb the operation.
         a = N'($urandom);
         b = N'($urandom);
         tc = 1'($urandom);
         in_valid = 1'b1;
      end
      wait_done(lat);
      in_valid = 1'b0;
      check({name, "_latency"}, 64'(lat), 64'(K + 1));
      check({name, "_p"}, 64'(p), 64'(exp));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check({name, "_stall_valid"}, 64'(out_valid), 64'(1));
         check({name, "_stall_p"}, 64'(p), 64'(exp));
         check({name, "_stall_inrdy"}, 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_release_valid"}, 64'(out_valid), 64'(0));
      check({name, "_release_inrdy"}, 64'(in_ready), 64'(1));
      check({name, "_release_p"}, 64'(p), 64'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int lat;
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic rtc;

      n_tests = 0;
      n_fail = 0;

      vecs[0] = '{10'd1023, 10'd1023, 1'b0, 20'hFF801};
      vecs[1] = '{10'h200,  10'h200,  1'b1, 20'h40000};
      vecs[2] = '{10'h3FF,  10'd1,    1'b1, 20'hFFFFF};
      vecs[3] = '{10'd0,    10'd777,  1'b0, 20'h00000};
      vecs[4] = '{10'd1,    10'd1023, 1'b0, 20'h003FF};
      vecs[5] = '{10'h1FF,  10'h1FF,  1'b1, 20'h3FC01};
      vecs[6] = '{10'h200,  10'h1FF,  1'b1, 20'hC0200};
      vecs[7] = '{10'h200,  10'h200,  1'b0, 20'h40000};
      vecs[8] = '{10'd1023, 10'd2,    1'b0, 20'h007FE};
      vecs[9] = '{10'h3FF,  10'h3FF,  1'b1, 20'h00001};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      tc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'(1));
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_p", 64'(p), 64'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vtc, vecs[i].vexp, 0, 0);
      end

      // Backpressure: 5 stalled DONE cycles with a new pair offered meanwhile.
      start(10'd100, 10'd200, 1'b0);
      wait_done(lat);
      check("bp_latency", 64'(lat), 64'(K + 1));
      a = 10'd7;
      b = 10'd9;
      tc = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", 64'(out_valid), 64'(1));
         check("bp_p", 64'(p), 64'(20000));
         check("bp_inrdy", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release_valid", 64'(out_valid), 64'(0));
      check("bp_release_inrdy", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_second_captured", 64'(in_ready), 64'(0));
      wait_done(lat);
      check("bp_second_latency", 64'(lat), 64'(K + 1));
      check("bp_second_p", 64'(p), 64'(63));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // out_ready already high when DONE is entered: single-cycle out_valid.
      out_ready = 1'b1;
      start(10'd3, 10'd5, 1'b0);
      wait_done(lat);
      check("hold_latency", 64'(lat), 64'(K + 1));
      check("hold_p", 64'(p), 64'(15));
      @(posedge clk);
      #1;
      check("hold_one_cycle", 64'(out_valid), 64'(0));
      check("hold_inrdy", 64'(in_ready), 64'(1));
      out_ready = 1'b0;

      // Reset on iteration 3 aborts the operation.
      start(10'd300, 10'd400, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_mid_valid", 64'(out_valid), 64'(0));
      check("rst_mid_p", 64'(p), 64'(0));
      check("rst_mid_inrdy", 64'(in_ready), 64'(1));
      for (int i = 0; i < K + 2; i++) begin
         @(posedge clk);
         #1;
         check("rst_mid_no_result", 64'(out_valid), 64'(0));
      end
      run_op("post_rst", 10'd5, 10'd6, 1'b0, 20'd30, 0, 0);

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 5))
            0: ra = '0;
            1: ra = '1;
            2: ra = {1'b1, {(N - 1){1'b0}}};
            default: ra = N'($urandom);
         endcase
         rb = ($urandom_range(0, 5) == 0) ? {1'b0, {(N - 1){1'b1}}} : N'($urandom);
         rtc = 1'($urandom);
         run_op($sformatf("rnd%0d", i), ra, rb, rtc, ref_mul(ra, rb, rtc),
                int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Iterative radix-4 Booth multiplier; next generation of the lab2 combinational unsigned 10x10 multiplier.
- Generalised in operand width and adds a signed/unsigned mode.
- Retires one Booth digit per clock cycle, using valid/ready handshakes on input and output.
- Sits between an operand source (FIFO or filter datapath) and a result consumer; area traded for latency.

Parameters:
- N, 10, operand width in bits; must be even and >= 4 (elaboration error otherwise).
- K, (N+2)/2, derived localparam: number of Booth iterations; not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  operands a, b, tc are valid.
- in_ready  out  1  block can accept a new operand pair.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- tc  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  product is valid.
- out_ready  in  1  consumer accepts the product.
- p  out  2N  product a*b (signed or unsigned per captured tc).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State becomes IDLE; in_ready=1, out_valid=0, p=0.
  - Internal accumulator and counter are cleared.
  - Reset overrides every other input and aborts any operation in progress; the aborted result is never presented.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a, b and tc, then go to BUSY with iteration counter = 0.
- Operand extension at capture:
  - Both operands are extended to W = N+2 bits: sign-extended if tc=1, zero-extended if tc=0.
  - This covers the unsigned top digit.
- BUSY:
  - in_ready=0; in_valid is ignored and no operand is captured.
  - Each edge consumes one radix-4 digit of extended b, from bits (2i+1, 2i, 2i-1), with bit -1 = 0.
  - Digit encoding: 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
  - Partial product weighted 4^i is added into a 2W-bit accumulator; negation is two's complement; accumulator arithmetic wraps modulo 2^(2W).
  - After the K-th iteration, go to DONE.
- DONE:
  - out_valid=1 and p = accumulator[2N-1:0], held stable.
  - The result is always exact for both modes, because a 2N-bit field holds the full-range product.
  - On an edge with out_ready=1, go to IDLE and set out_valid=0; p keeps its last value.
  - in_ready=0 in DONE, so there is no overlap.
- Latency and throughput:
  - out_valid rises exactly K+1 edges after the input-handshake edge: 1 capture edge plus K iteration edges. For N=10 this is 7 edges.
  - Minimum initiation interval is K+2 cycles, since the DONE->IDLE transition takes one cycle.
- Simultaneous events:
  - out_ready held at 1 when DONE is entered: handshake completes on the first DONE edge, so out_valid is high for exactly one cycle.
  - in_valid asserted during BUSY/DONE: no effect; the source must hold in_valid until it sees in_ready.
  - tc changes after capture: no effect on the current operation.
- Output stability: p and out_valid change only on clk edges; no combinational path from any input to any output.

Test Plan:
- Unsigned max: N=10, tc=0, a=1023, b=1023 -> p=1046529 (0xFF801); out_valid 7 edges after accept.
- Signed corner: tc=1.
  - a=0x200 (-512), b=0x200 (-512) -> p=262144 (0x40000).
  - a=0x3FF (-1), b=1 -> p=0xFFFFF.
- Zero and identity: tc=0, a=0, b=777 -> p=0; a=1, b=1023 -> p=1023.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and p held constant, in_ready=0; raising out_ready returns to IDLE the next edge. A pair offered during the stall is accepted only after that.
- Reset mid-operation: rst_n=0 on iteration 3 of a=300, b=400 -> next edge IDLE, out_valid=0, p=0, in_ready=1. A new pair a=5, b=6 then yields p=30.
- Exhaustive check (N=10, both tc modes): all 2^20 pairs compared against the software product; mismatch count must be 0. Repeat with N=4 and N=16 on random pairs.
